dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory (`data_mem`: synchronous write, combinational read) between the ARM core's load/store path (port 0) and a second bus master such as a program/data loader (port 1). It sits between both requesters and `dmem` in the top level and sequences one memory access at a time. Each access uses a req/ack handshake, with round-robin fairness by default.

---
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port req/ack arbiter sharing one data memory between core and loader.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [1:0]        gnt
);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } stateT;

  stateT state;
  logic  last;
  logic  ereq0;
  logic  ereq1;
  logic  pick1;

  // A port in its ack cycle is masked so it can change or drop its request.
  assign ereq0 = m0_req & ~m0_ack;
  assign ereq1 = m1_req & ~m1_ack;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign pick1 = ereq1 & ~ereq0;
`else
  assign pick1 = ereq1 & (~ereq0 | ~last);
`endif

  assign gnt = {state == GNT1, state == GNT0};

  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    unique case (1'b1)
      state == GNT0: begin
        mem_we = m0_we;
        mem_a  = m0_addr;
        mem_wd = m0_wdata;
      end
      state == GNT1: begin
        mem_we = m1_we;
        mem_a  = m1_addr;
        mem_wd = m1_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ereq0 | ereq1)
            state <= pick1 ? GNT1 : GNT0;
        end
        GNT0: begin
          m0_ack <= 1'b1;
          if (!m0_we)
            m0_rdata <= mem_rd;
          last  <= 1'b0;
          state <= IDLE;
        end
        GNT1: begin
          m1_ack <= 1'b1;
          if (!m1_we)
            m1_rdata <= mem_rd;
          last  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level arbiter model.
// Includes a behavioural data memory on the memory port.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic [1:0]  gnt;

  logic [31:0] ram    [256];
  logic [31:0] refMem [256];

  int          owner;
  int          lastSrv;
  logic        expAck [2];
  logic [31:0] expRd  [2];
  int          nChecks;
  int          nFails;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (req[0]),
    .m0_we    (we[0]),
    .m0_addr  (addr[0]),
    .m0_wdata (wdata[0]),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m1_req   (req[1]),
    .m1_we    (we[1]),
    .m1_addr  (addr[1]),
    .m1_wdata (wdata[1]),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd),
    .gnt      (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = ram[mem_a[9:2]];
  always @(posedge clk)
    if (mem_we) ram[mem_a[9:2]] <= mem_wd;

  function automatic logic [31:0] initVal(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  task automatic chkEq(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    owner   = -1;
    lastSrv = 1;
    expAck  = '{1'b0, 1'b0};
    expRd   = '{32'h0, 32'h0};
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelNext();
    logic nAck [2];
    logic e0, e1;
    nAck = '{1'b0, 1'b0};
    if (owner >= 0) begin
      nAck[owner] = 1'b1;
      if (we[owner])
        refMem[addr[owner][9:2]] = wdata[owner];
      else
        expRd[owner] = refMem[addr[owner][9:2]];
      lastSrv = owner;
      owner   = -1;
    end else begin
      e0 = req[0] && !expAck[0];
      e1 = req[1] && !expAck[1];
`ifdef DMEM_ARB_FIXED_PRIO_EN
      if (e0) owner = 0;
      else if (e1) owner = 1;
`else
      if (e0 && e1) owner = (lastSrv == 0) ? 1 : 0;
      else if (e0) owner = 0;
      else if (e1) owner = 1;
`endif
    end
    expAck = nAck;
  endtask

  task automatic checkOutputs();
    chkEq("gnt", 64'(gnt), (owner == 0) ? 64'd1 : (owner == 1) ? 64'd2 : 64'd0);
    chkEq("mem_we", 64'(mem_we), (owner >= 0) ? 64'(we[owner]) : 64'd0);
    chkEq("mem_a", 64'(mem_a), (owner >= 0) ? 64'(addr[owner]) : 64'd0);
    chkEq("mem_wd", 64'(mem_wd), (owner >= 0) ? 64'(wdata[owner]) : 64'd0);
    chkEq("m0_ack", 64'(m0_ack), 64'(expAck[0]));
    chkEq("m1_ack", 64'(m1_ack), 64'(expAck[1]));
    chkEq("m0_rdata", 64'(m0_rdata), 64'(expRd[0]));
    chkEq("m1_rdata", 64'(m1_rdata), 64'(expRd[1]));
  endtask

  task automatic step();
    modelNext();
    @(posedge clk);
    @(negedge clk);
    checkOutputs();
  endtask

  task automatic newReq(input int k);
    req[k]   = 1'b1;
    we[k]    = 1'($urandom_range(0, 1));
    addr[k]  = 32'($urandom_range(0, 63)) << 2;
    wdata[k] = $urandom;
  endtask

  task automatic setReq(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] d);
    req[k]   = 1'b1;
    we[k]    = w;
    addr[k]  = a;
    wdata[k] = d;
  endtask

  task automatic drive(input int k);
    if (req[k] && expAck[k]) begin
      if ($urandom_range(0, 1) == 1) newReq(k);
      else req[k] = 1'b0;
    end else if (req[k] && owner != k) begin
      if ($urandom_range(0, 15) == 0) req[k] = 1'b0;
    end else if (!req[k]) begin
      if ($urandom_range(0, 2) == 0) newReq(k);
    end
  endtask

  initial begin
    int acks;
    nChecks = 0;
    nFails  = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i]    = initVal(i);
      refMem[i] = initVal(i);
    end
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    reset = 1'b1;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutputs();
    reset = 1'b0;
    step();

    // Port-0 write, then port-1 read-back of the same word.
    setReq(0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    step();
    chkEq("wr_gnt", 64'(gnt), 64'd1);
    step();
    req[0] = 1'b0;
    setReq(1, 1'b0, 32'h40, 32'h0);
    step();
    step();
    chkEq("rd_back", 64'(m1_rdata), 64'hDEAD_BEEF);
    req[1] = 1'b0;
    step();

    // Both ports saturated.
    setReq(0, 1'b0, 32'h10, 32'h0);
    setReq(1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 12; i++) step();
    req[0] = 1'b0;
    req[1] = 1'b0;
    step();
    step();

    // One port streaming three reads.
    acks = 0;
    setReq(0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 20 && acks < 3; i++) begin
      step();
      if (expAck[0]) begin
        acks++;
        addr[0] = addr[0] + 32'd4;
        if (acks == 3) req[0] = 1'b0;
      end
    end
    chkEq("stream_acks", 64'(acks), 64'd3);
    step();

    // Reset in the middle of a port-1 write.
    setReq(1, 1'b1, 32'h80, 32'h1234_5678);
    step();
    reset = 1'b1;
    #1;
    chkEq("rst_mem_we", 64'(mem_we), 64'd0);
    chkEq("rst_gnt", 64'(gnt), 64'd0);
    modelReset();
    req[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checkOutputs();
    setReq(0, 1'b0, 32'h80, 32'h0);
    step();
    step();
    chkEq("rst_old", 64'(m0_rdata), 64'(initVal(32)));
    req[0] = 1'b0;
    step();

    // Port 0 pulses its request while port 1 owns the memory.
    setReq(1, 1'b0, 32'h24, 32'h0);
    step();
    setReq(0, 1'b1, 32'h28, 32'hCAFE_F00D);
    req[1] = 1'b0;
    step();
    req[0] = 1'b0;
    for (int i = 0; i < 3; i++) step();

    for (int c = 0; c < 3000; c++) begin
      drive(0);
      drive(1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
